// File: rtl/al_accel_pkg.sv
// al_accel_pkg
// Shared definitions for the accelerator pipeline stages:
//   - layer-type codes carried on cfg_layer_typ (CONV / DENSE / POOL)
//   - write-back stage FSM state encoding
//   - byte-strobe helper for single-byte writes
package al_accel_pkg;

    localparam logic [3:0] LAYER_CONV  = 4'd0;
    localparam logic [3:0] LAYER_DENSE = 4'd1;
    localparam logic [3:0] LAYER_POOL  = 4'd2;

    typedef enum logic [2:0] {
        G_START  = 3'd0,
        G_IDLE   = 3'd1,
        G_READ   = 3'd2,
        G_QUANT  = 3'd3,
        G_WRITE  = 3'd4,
        G_FINISH = 3'd5
    } wback_state_t;

    // One-hot strobe for a single byte at the given byte offset in a word.
    function automatic logic [3:0] byte_strb(input logic [1:0] offs);
        return 4'b0001 << offs;
    endfunction

endpackage

// File: rtl/al_accel_wback_quant.sv
// al_accel_wback_quant
// Purely combinational quantizer for final outputs:
//   optional ReLU, round-half-up, arithmetic right shift, int8 saturation.
// Build option: define WBACK_RELU_EN to clamp negative inputs to zero first.
// Ports:
//   acc   in  ACC_W  signed accumulator word
//   qsel  in  4      right-shift amount (0 = no shift, no rounding)
//   q     out 8      saturated int8 result
module al_accel_wback_quant #(
    parameter int ACC_W = 32
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [3:0]       qsel,
    output logic [7:0]       q
);

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] SAT_MIN = -(ACC_W+1)'(128);

    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W:0]   rnd;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W:0]   shifted;

    always_comb begin
`ifdef WBACK_RELU_EN
        x = acc[ACC_W-1] ? '0 : $signed(acc);
`else
        x = $signed(acc);
`endif
        rnd = '0;
        if (qsel != 4'd0) begin
            rnd = (ACC_W+1)'(1) << (qsel - 4'd1);
        end
        // One extra bit of headroom so the rounding add cannot wrap.
        sum     = $signed({x[ACC_W-1], x}) + rnd;
        shifted = sum >>> qsel;
        // Saturate on the full-width value, then truncate.
        if (shifted > SAT_MAX) begin
            q = 8'h7F;
        end else if (shifted < SAT_MIN) begin
            q = 8'h80;
        end else begin
            q = shifted[7:0];
        end
    end

endmodule

// File: rtl/al_accel_wback_ctrl.sv
// al_accel_wback_ctrl
// Write-back stage controller. Accepts one job per COMPS hand-off, reads
// NUM_ACC accumulator words and writes each to memory: partial sums as raw
// 32-bit words, final outputs quantized to int8 and written as single bytes.
// Build option: WBACK_RELU_EN (applies ReLU to final outputs, see quant).
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   enb                    stage enable; 0 freezes all state, masks wr_valid
//   cfg_layer_typ          layer type; POOL keeps the stage parked in G_START
//   COMPS_*                COMPS status and job fields (captured on accept)
//   RDATA_rdy, RDATA_fin   upstream read stage status
//   acc_rd_en/idx/data     accumulator read port (data one cycle after en)
//   wr_valid/addr/data/strb/ready  memory write handshake
//   WBACK_start/rdy/fin    stage status back to COMPS
module al_accel_wback_ctrl
    import al_accel_pkg::*;
#(
    parameter int NUM_ACC = 3,
    parameter int ACC_W   = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enb,
    input  logic [3:0]       cfg_layer_typ,
    input  logic             COMPS_start,
    input  logic             COMPS_rdy,
    input  logic             COMPS_fin,
    input  logic             COMPS_is_out_fin,
    input  logic [31:0]      COMPS_ps_addr,
    input  logic [31:0]      COMPS_o_addr,
    input  logic [3:0]       COMPS_o_quant_sel,
    input  logic             RDATA_rdy,
    input  logic             RDATA_fin,
    output logic             acc_rd_en,
    output logic [3:0]       acc_rd_idx,
    input  logic [ACC_W-1:0] acc_rd_data,
    output logic             wr_valid,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic [3:0]       wr_strb,
    input  logic             wr_ready,
    output logic             WBACK_start,
    output logic             WBACK_rdy,
    output logic             WBACK_fin
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ACC - 1);

    wback_state_t state_reg;
    logic [3:0]   idx_reg;
    logic         is_out_reg;
    logic [31:0]  ps_addr_reg;
    logic [31:0]  o_addr_reg;
    logic [3:0]   qsel_reg;
    logic [31:0]  wr_addr_reg;
    logic [31:0]  wr_data_reg;
    logic [3:0]   wr_strb_reg;

    logic [31:0]  wr_addr_next;
    logic [31:0]  wr_data_next;
    logic [3:0]   wr_strb_next;
    logic [7:0]   q_byte;
    logic [31:0]  q_word;
    logic         rd_ok;
    logic         accept;

    assign WBACK_start = (state_reg == G_START);
    assign WBACK_rdy   = (state_reg == G_IDLE);
    assign WBACK_fin   = (state_reg == G_FINISH);
    assign acc_rd_en   = (state_reg == G_READ);
    assign acc_rd_idx  = idx_reg;
    assign wr_valid    = (state_reg == G_WRITE) && enb;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign wr_strb     = wr_strb_reg;

    assign rd_ok  = RDATA_rdy || RDATA_fin;
    // Same edge at which COMPS reloads its pipeline flops, so the COMPS_*
    // values seen now belong to the job being handed over.
    assign accept = COMPS_rdy && WBACK_rdy && rd_ok && enb;

    al_accel_wback_quant #(
        .ACC_W (ACC_W)
    ) u_quant (
        .acc  (acc_rd_data),
        .qsel (qsel_reg),
        .q    (q_byte)
    );

    // Final-output byte is replicated so the strobe alone selects the lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign q_word[8*gi +: 8] = q_byte;
        end
    endgenerate

    always_comb begin
        wr_addr_next = ps_addr_reg + (32'(idx_reg) << 2);
        wr_data_next = 32'(acc_rd_data);
        wr_strb_next = 4'b1111;
        if (is_out_reg) begin
            wr_addr_next = o_addr_reg + 32'(idx_reg);
            wr_data_next = q_word;
            wr_strb_next = byte_strb(wr_addr_next[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= G_START;
            idx_reg     <= '0;
            is_out_reg  <= 1'b0;
            ps_addr_reg <= '0;
            o_addr_reg  <= '0;
            qsel_reg    <= '0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            wr_strb_reg <= '0;
        end else if (enb) begin
            case (state_reg)
                G_START: begin
                    if (cfg_layer_typ != LAYER_POOL && COMPS_start && rd_ok) begin
                        state_reg <= G_IDLE;
                    end
                end
                G_IDLE: begin
                    // Accept wins over COMPS_fin; finish is taken from a
                    // later idle cycle once the accepted job has drained.
                    if (accept) begin
                        is_out_reg  <= COMPS_is_out_fin;
                        ps_addr_reg <= COMPS_ps_addr;
                        o_addr_reg  <= COMPS_o_addr;
                        qsel_reg    <= COMPS_o_quant_sel;
                        idx_reg     <= '0;
                        state_reg   <= G_READ;
                    end else if (COMPS_fin) begin
                        state_reg <= G_FINISH;
                    end
                end
                G_READ: begin
                    state_reg <= G_QUANT;
                end
                G_QUANT: begin
                    wr_addr_reg <= wr_addr_next;
                    wr_data_reg <= wr_data_next;
                    wr_strb_reg <= wr_strb_next;
                    state_reg   <= G_WRITE;
                end
                G_WRITE: begin
                    if (wr_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= G_IDLE;
                        end else begin
                            idx_reg   <= idx_reg + 4'd1;
                            state_reg <= G_READ;
                        end
                    end
                end
                G_FINISH: begin
                    state_reg <= G_FINISH;
                end
                default: begin
                    state_reg <= G_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_al_accel_wback_ctrl.sv
module tb_al_accel_wback_ctrl;

    localparam int NUM_ACC = 3;
    localparam int ACC_W   = 32;

    logic             clk = 1'b0;
    logic             resetn;
    logic             enb;
    logic [3:0]       cfg_layer_typ;
    logic             COMPS_start, COMPS_rdy, COMPS_fin, COMPS_is_out_fin;
    logic [31:0]      COMPS_ps_addr, COMPS_o_addr;
    logic [3:0]       COMPS_o_quant_sel;
    logic             RDATA_rdy, RDATA_fin;
    logic             acc_rd_en;
    logic [3:0]       acc_rd_idx;
    logic [ACC_W-1:0] acc_rd_data;
    logic             wr_valid;
    logic [31:0]      wr_addr, wr_data;
    logic [3:0]       wr_strb;
    logic             wr_ready;
    logic             WBACK_start, WBACK_rdy, WBACK_fin;

    al_accel_wback_ctrl #(.NUM_ACC(NUM_ACC), .ACC_W(ACC_W)) dut (
        .clk(clk), .resetn(resetn), .enb(enb), .cfg_layer_typ(cfg_layer_typ),
        .COMPS_start(COMPS_start), .COMPS_rdy(COMPS_rdy), .COMPS_fin(COMPS_fin),
        .COMPS_is_out_fin(COMPS_is_out_fin), .COMPS_ps_addr(COMPS_ps_addr),
        .COMPS_o_addr(COMPS_o_addr), .COMPS_o_quant_sel(COMPS_o_quant_sel),
        .RDATA_rdy(RDATA_rdy), .RDATA_fin(RDATA_fin),
        .acc_rd_en(acc_rd_en), .acc_rd_idx(acc_rd_idx), .acc_rd_data(acc_rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_ready(wr_ready),
        .WBACK_start(WBACK_start), .WBACK_rdy(WBACK_rdy), .WBACK_fin(WBACK_fin)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] acc_mem [0:15];

    // Accumulator matrix model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_idx];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_t e;
        e.addr = a; e.data = d; e.strb = s;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: one line per accepted write.
    always @(negedge clk) begin
        if (wr_valid && wr_ready) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr %h data %h strb %h, required no write",
                         wr_addr, wr_data, wr_strb);
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data || wr_strb !== e.strb) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h strb %h, required addr %h data %h strb %h",
                             wr_addr, wr_data, wr_strb, e.addr, e.data, e.strb);
                end else begin
                    $display("ok   write: addr %h data %h strb %h", wr_addr, wr_data, wr_strb);
                end
            end
        end
    end

    task automatic wait_rdy(input string name);
        int n = 0;
        @(negedge clk);
        while (!WBACK_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, WBACK_rdy}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!wr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, wr_valid}, 32'd1);
    endtask

    task automatic issue_job(input logic is_out, input logic [31:0] ps, input logic [31:0] oa,
                             input logic [3:0] qsel, input logic fin,
                             input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        wait_rdy("idle_before_job");
        acc_mem[0] = w0; acc_mem[1] = w1; acc_mem[2] = w2;
        COMPS_is_out_fin  = is_out;
        COMPS_ps_addr     = ps;
        COMPS_o_addr      = oa;
        COMPS_o_quant_sel = qsel;
        COMPS_fin         = fin;
        COMPS_rdy         = 1'b1;
        @(negedge clk);
        COMPS_rdy     = 1'b0;
        COMPS_ps_addr = 32'hDEAD_BEEF;  // job fields must already be captured
        COMPS_o_addr  = 32'hDEAD_BEEF;
        chk("rdy_drops_after_accept", {31'd0, WBACK_rdy}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        logic [31:0] exp_relu_a, exp_relu_b;
`ifdef WBACK_RELU_EN
        exp_relu_a = 32'h0000_0000;
        exp_relu_b = 32'h0000_0000;
`else
        exp_relu_a = 32'hFAFA_FAFA;
        exp_relu_b = 32'h8080_8080;
`endif
        for (int i = 0; i < 16; i++) acc_mem[i] = '0;
        acc_rd_data = '0;
        resetn = 1'b0; enb = 1'b1; cfg_layer_typ = 4'd0;
        COMPS_start = 1'b0; COMPS_rdy = 1'b0; COMPS_fin = 1'b0; COMPS_is_out_fin = 1'b0;
        COMPS_ps_addr = '0; COMPS_o_addr = '0; COMPS_o_quant_sel = '0;
        RDATA_rdy = 1'b1; RDATA_fin = 1'b0; wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("reset_start", {31'd0, WBACK_start}, 32'd1);
        chk("reset_rdy", {31'd0, WBACK_rdy}, 32'd0);
        chk("reset_fin", {31'd0, WBACK_fin}, 32'd0);
        chk("reset_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("reset_acc_rd_en", {31'd0, acc_rd_en}, 32'd0);
        chk("reset_wr_addr", wr_addr, 32'd0);
        chk("reset_wr_data", wr_data, 32'd0);
        chk("reset_wr_strb", {28'd0, wr_strb}, 32'd0);

        // POOL layer keeps the stage parked in G_START.
        cfg_layer_typ = 4'd2;
        COMPS_start   = 1'b1;
        repeat (4) @(negedge clk);
        chk("pool_stays_start", {31'd0, WBACK_start}, 32'd1);
        chk("pool_not_idle", {31'd0, WBACK_rdy}, 32'd0);
        cfg_layer_typ = 4'd0;

        // J1: partial sums, raw words.
        push(32'h100, 32'h0000_0005, 4'hF);
        push(32'h104, 32'hFFFF_FFF9, 4'hF);
        push(32'h108, 32'h1234_5678, 4'hF);
        issue_job(1'b0, 32'h100, 32'h0, 4'd0, 1'b0, 32'd5, -32'sd7, 32'h1234_5678);
        COMPS_start = 1'b0;

        // J2: final outputs, qsel=4, byte writes from 0x203.
        push(32'h203, 32'h0606_0606, 4'b1000);
        push(32'h204, 32'h3F3F_3F3F, 4'b0001);
        push(32'h205, exp_relu_a,    4'b0010);
        issue_job(1'b1, 32'h0, 32'h203, 4'd4, 1'b0, 32'd100, 32'd1000, -32'sd100);

        // J3: saturation with qsel=0.
        push(32'h300, 32'h7F7F_7F7F, 4'b0001);
        push(32'h301, exp_relu_b,    4'b0010);
        push(32'h302, 32'h7F7F_7F7F, 4'b0100);
        issue_job(1'b1, 32'h0, 32'h300, 4'd0, 1'b0, 32'd1000, -32'sd1000, 32'd127);

        // J4: partial sums under backpressure, COMPS_fin raised with the accept.
        push(32'h400, 32'hFFFF_FFFF, 4'hF);
        push(32'h404, 32'h8000_0000, 4'hF);
        push(32'h408, 32'h0000_002A, 4'hF);
        wait_rdy("idle_before_bp");
        wr_ready = 1'b0;
        issue_job(1'b0, 32'h400, 32'h0, 4'd0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd42);
        wait_valid("bp_first_valid");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 enb = (k == 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            chk("bp_valid", {31'd0, wr_valid}, (k == 2) ? 32'd0 : 32'd1);
            chk("bp_addr", wr_addr, 32'h400);
            chk("bp_data", wr_data, 32'hFFFF_FFFF);
            chk("bp_strb", {28'd0, wr_strb}, 32'hF);
            chk("bp_rdy_low", {31'd0, WBACK_rdy}, 32'd0);
            chk("bp_fin_low", {31'd0, WBACK_fin}, 32'd0);
        end
        @(posedge clk);
        #1 enb = 1'b1; wr_ready = 1'b1;

        n = 0;
        @(negedge clk);
        while (!WBACK_fin && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("fin_reached", {31'd0, WBACK_fin}, 32'd1);
        chk("fin_after_all_writes", exp_q.size(), 32'd0);
        chk("fin_not_rdy", {31'd0, WBACK_rdy}, 32'd0);
        COMPS_fin = 1'b0;

        // Reset in the middle of a write aborts the job.
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1; COMPS_start = 1'b1;
        wait_rdy("restart_idle");
        COMPS_start = 1'b0;
        wr_ready = 1'b0;
        issue_job(1'b0, 32'h500, 32'h0, 4'd0, 1'b0, 32'd1, 32'd2, 32'd3);
        wait_valid("abort_job_valid");
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("abort_start", {31'd0, WBACK_start}, 32'd1);
        chk("abort_wr_valid", {31'd0, wr_valid}, 32'd0);
        wr_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_valid) seen++;
        end
        chk("abort_no_more_writes", seen, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
